// File: rtl/iss_read_sequencer.sv
// ISS gimbal angle readout sequencer: one X->Y->Z sweep per interrogate pulse,
// sharing a single resolver conversion resource through a req/ack handshake.
module iss_read_sequencer #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_issihi,
    input  logic [2:0]  i_chan_en,
    input  logic        i_err_clr,
    input  logic        i_conv_ack,
    input  logic [15:0] i_conv_data,
    output logic        o_conv_req,
    output logic [1:0]  o_conv_sel,
    output logic [15:0] o_angle_x,
    output logic [15:0] o_angle_y,
    output logic [15:0] o_angle_z,
    output logic [2:0]  o_angle_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overrun,
    output logic [2:0]  o_timeout_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_REQ, ST_NEXT} state_t;

    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_s1, r_s2, r_s3;
    logic [1:0]  r_fill;
    logic        r_armed;
    logic        w_trig;
    logic [7:0]  r_cnt;
    logic [2:0]  r_en;
    logic [1:0]  r_ch;
    logic [15:0] r_angle [3];
    logic [2:0]  r_valid;
    logic        r_done;
    logic        r_overrun;
    logic [2:0]  r_tmo;
    logic [2:0]  w_first;
    logic [2:0]  w_above;
    logic [2:0]  w_next;
    logic        w_ack_take;
    logic        w_tmo_hit;

    // {found, channel} of the lowest set bit
    function automatic logic [2:0] pick_lowest(input logic [2:0] m);
        if (m[0])      return 3'b100;
        else if (m[1]) return 3'b101;
        else if (m[2]) return 3'b110;
        else           return 3'b000;
    endfunction

    // A level already high when reset releases must not count as an edge:
    // arm only after the synchronizer has been observed low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_fill  <= 2'd0;
            r_armed <= 1'b0;
        end else begin
            r_s1    <= i_issihi;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_fill  <= (r_fill == 2'd2) ? r_fill : r_fill + 2'd1;
            r_armed <= r_armed | ((r_fill == 2'd2) & ~r_s2);
        end
    end

    assign w_trig  = r_s2 & ~r_s3 & r_armed;
    assign w_first = pick_lowest(i_chan_en);
    assign w_above = (r_ch == 2'd0) ? (r_en & 3'b110) :
                     (r_ch == 2'd1) ? (r_en & 3'b100) : 3'b000;
    assign w_next  = pick_lowest(w_above);

    always_comb begin
        w_state_next = r_state;
        w_ack_take   = 1'b0;
        w_tmo_hit    = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_trig && w_first[2]) w_state_next = ST_SETTLE;
            ST_SETTLE: if (r_cnt == SETTLE_LAST) w_state_next = ST_REQ;
            ST_REQ: begin
                // an ack arriving on the final allowed cycle still counts
                if (i_conv_ack) begin
                    w_ack_take   = 1'b1;
                    w_state_next = ST_NEXT;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_tmo_hit    = 1'b1;
                    w_state_next = ST_NEXT;
                end
            end
            ST_NEXT:   w_state_next = w_next[2] ? ST_SETTLE : ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_en    <= 3'b000;
            r_ch    <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (w_state_next != r_state || r_state == ST_IDLE) ? 8'd0 : r_cnt + 8'd1;
            if (r_state == ST_IDLE && w_trig && w_first[2]) begin
                r_en <= i_chan_en;
                r_ch <= w_first[1:0];
            end else if (r_state == ST_NEXT && w_next[2]) begin
                r_ch <= w_next[1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) r_angle[i] <= 16'h0000;
            r_valid   <= 3'b000;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_tmo     <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++)
                if (w_ack_take && r_ch == 2'(i)) r_angle[i] <= i_conv_data;
            r_valid   <= w_ack_take ? (3'b001 << r_ch) : 3'b000;
            r_done    <= (r_state == ST_NEXT) && !w_next[2];
            r_overrun <= (r_overrun & ~i_err_clr) | (w_trig && r_state != ST_IDLE);
            r_tmo     <= (r_tmo & {3{~i_err_clr}}) | (w_tmo_hit ? (3'b001 << r_ch) : 3'b000);
        end
    end

    assign o_conv_req    = (r_state == ST_REQ);
    assign o_conv_sel    = r_ch;
    assign o_angle_x     = r_angle[0];
    assign o_angle_y     = r_angle[1];
    assign o_angle_z     = r_angle[2];
    assign o_angle_valid = r_valid;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = r_done;
    assign o_overrun     = r_overrun;
    assign o_timeout_err = r_tmo;

endmodule

// File: tb/tb_iss_read_sequencer.sv
// Directed and randomized sweeps of iss_read_sequencer checked against a
// sweep-level reference model (per-channel outcome from enable mask and ack delay).
module tb_iss_read_sequencer;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst;
    logic        i_issihi;
    logic [2:0]  i_chan_en;
    logic        i_err_clr;
    logic        i_conv_ack;
    logic [15:0] i_conv_data;
    logic        o_conv_req;
    logic [1:0]  o_conv_sel;
    logic [15:0] o_angle_x, o_angle_y, o_angle_z;
    logic [2:0]  o_angle_valid;
    logic        o_busy, o_done, o_overrun;
    logic [2:0]  o_timeout_err;

    iss_read_sequencer #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .i_issihi(i_issihi), .i_chan_en(i_chan_en),
        .i_err_clr(i_err_clr), .i_conv_ack(i_conv_ack), .i_conv_data(i_conv_data),
        .o_conv_req(o_conv_req), .o_conv_sel(o_conv_sel),
        .o_angle_x(o_angle_x), .o_angle_y(o_angle_y), .o_angle_z(o_angle_z),
        .o_angle_valid(o_angle_valid), .o_busy(o_busy), .o_done(o_done),
        .o_overrun(o_overrun), .o_timeout_err(o_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // conversion responder settings: delay < 0 means never ack
    int          rsp_delay [4];
    logic [15:0] rsp_data  [4];
    logic        stray_ack;

    // monitor observations
    int n_busy = 0, n_done = 0;
    int n_valid [3];
    int sel_q [$];
    int len_q [$];

    // reference model state
    logic [15:0] m_angle [3];
    logic [2:0]  m_tmo;
    logic        m_ovr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int age;
        logic hit;
        age = 0;
        i_conv_ack = 1'b0;
        i_conv_data = 16'h0000;
        forever begin
            @(negedge clk);
            age = o_conv_req ? age + 1 : 0;
            hit = o_conv_req && rsp_delay[o_conv_sel] >= 0 && age == rsp_delay[o_conv_sel] + 1;
            i_conv_ack  = hit || stray_ack;
            i_conv_data = hit ? rsp_data[o_conv_sel] : 16'($urandom);
        end
    end

    initial begin
        logic prev_req;
        int cur_len;
        prev_req = 1'b0;
        cur_len = 0;
        for (int i = 0; i < 3; i++) n_valid[i] = 0;
        forever begin
            @(negedge clk);
            if (o_busy) n_busy++;
            if (o_done) n_done++;
            for (int i = 0; i < 3; i++) if (o_angle_valid[i]) n_valid[i]++;
            if (o_conv_req && !prev_req) sel_q.push_back(int'(o_conv_sel));
            if (o_conv_req) cur_len++;
            if (!o_conv_req && prev_req) begin
                len_q.push_back(cur_len);
                cur_len = 0;
            end
            prev_req = o_conv_req;
        end
    end

    task automatic pulse_issihi();
        @(negedge clk) i_issihi = 1'b1;
        repeat (4) @(negedge clk);
        i_issihi = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input logic [2:0] en,
                             input int d0, input int d1, input int d2,
                             input logic [15:0] a0, input logic [15:0] a1,
                             input logic [15:0] a2, input bit second_trig);
        int b_busy, b_done, b_sel, b_len, exp_busy, exp_done;
        int b_valid [3];
        int exp_valid [3];
        int dly [3];
        logic [15:0] dat [3];
        int exp_sel [$];
        int exp_len [$];
        int cnt;
        dly[0] = d0; dly[1] = d1; dly[2] = d2;
        dat[0] = a0; dat[1] = a1; dat[2] = a2;
        for (int c = 0; c < 3; c++) begin
            rsp_delay[c] = dly[c];
            rsp_data[c]  = dat[c];
            b_valid[c]   = n_valid[c];
            exp_valid[c] = 0;
        end
        b_busy = n_busy; b_done = n_done; b_sel = sel_q.size(); b_len = len_q.size();

        exp_busy = 0;
        for (int c = 0; c < 3; c++) begin
            if (en[c]) begin
                bit acked;
                int rl;
                acked = dly[c] >= 0 && dly[c] < TIMEOUT;
                rl = acked ? dly[c] + 1 : TIMEOUT;
                exp_sel.push_back(c);
                exp_len.push_back(rl);
                exp_busy += SETTLE + rl + 1;
                if (acked) begin
                    m_angle[c] = dat[c];
                    exp_valid[c] = 1;
                end else begin
                    m_tmo[c] = 1'b1;
                end
            end
        end
        exp_done = (en != 3'b000) ? 1 : 0;
        if (second_trig) m_ovr = 1'b1;

        i_chan_en = en;
        pulse_issihi();
        if (en != 3'b000) begin
            cnt = 0;
            while (!o_busy && cnt < 20) begin @(negedge clk); cnt++; end
            check({tag, "_start"}, 32'(o_busy), 32'd1);
            i_chan_en = 3'($urandom);
            if (second_trig) begin
                repeat (2) @(negedge clk);
                pulse_issihi();
            end
            cnt = 0;
            while (o_busy && cnt < 1000) begin @(negedge clk); cnt++; end
            check({tag, "_end"}, 32'(o_busy), 32'd0);
        end
        repeat (12) @(negedge clk);

        check({tag, "_angle_x"}, 32'(o_angle_x), 32'(m_angle[0]));
        check({tag, "_angle_y"}, 32'(o_angle_y), 32'(m_angle[1]));
        check({tag, "_angle_z"}, 32'(o_angle_z), 32'(m_angle[2]));
        check({tag, "_tmo"}, 32'(o_timeout_err), 32'(m_tmo));
        check({tag, "_ovr"}, 32'(o_overrun), 32'(m_ovr));
        check({tag, "_done_cnt"}, 32'(n_done - b_done), 32'(exp_done));
        check({tag, "_busy_cyc"}, 32'(n_busy - b_busy), 32'(exp_busy));
        for (int c = 0; c < 3; c++)
            check($sformatf("%s_valid%0d", tag, c), 32'(n_valid[c] - b_valid[c]), 32'(exp_valid[c]));
        check({tag, "_nsel"}, 32'(sel_q.size() - b_sel), 32'(exp_sel.size()));
        for (int k = 0; k < exp_sel.size() && b_sel + k < sel_q.size(); k++)
            check($sformatf("%s_sel%0d", tag, k), 32'(sel_q[b_sel + k]), 32'(exp_sel[k]));
        for (int k = 0; k < exp_len.size() && b_len + k < len_q.size(); k++)
            check($sformatf("%s_reqlen%0d", tag, k), 32'(len_q[b_len + k]), 32'(exp_len[k]));
        $display("sweep %s en=%b delays=%0d/%0d/%0d busy=%0d angles=%h/%h/%h tmo=%b ovr=%b",
                 tag, en, d0, d1, d2, n_busy - b_busy, o_angle_x, o_angle_y, o_angle_z,
                 o_timeout_err, o_overrun);
    endtask

    task automatic clear_errors(input string tag);
        @(negedge clk) i_err_clr = 1'b1;
        @(negedge clk) i_err_clr = 1'b0;
        m_tmo = 3'b000;
        m_ovr = 1'b0;
        check({tag, "_tmo"}, 32'(o_timeout_err), 32'd0);
        check({tag, "_ovr"}, 32'(o_overrun), 32'd0);
        $display("err_clr %s tmo=%b ovr=%b", tag, o_timeout_err, o_overrun);
    endtask

    initial begin
        int cnt, b_busy, dsel [3];
        rst = 1'b1; i_issihi = 1'b0; i_chan_en = 3'b000; i_err_clr = 1'b0; stray_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin rsp_delay[c] = -1; rsp_data[c] = 16'h0000; end
        for (int c = 0; c < 3; c++) m_angle[c] = 16'h0000;
        m_tmo = 3'b000; m_ovr = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req", 32'(o_conv_req), 32'd0);
        check("rst_sel", 32'(o_conv_sel), 32'd0);
        check("rst_angles", {o_angle_x, o_angle_y | o_angle_z}, 32'd0);
        check("rst_valid", 32'(o_angle_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_flags", {o_overrun, o_timeout_err}, 32'd0);
        $display("reset checks done");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        run_sweep("full", 3'b111, 2, 2, 2, 16'h1111, 16'h2222, 16'h3333, 1'b0);
        run_sweep("skip", 3'b101, 0, 0, 0, 16'hA5A5, 16'hBEEF, 16'h5A5A, 1'b0);
        run_sweep("timeout", 3'b111, 1, -1, 3, 16'h0102, 16'h0304, 16'h0506, 1'b0);
        clear_errors("clr1");
        run_sweep("overrun", 3'b111, 2, 2, 2, 16'h7777, 16'h8888, 16'h9999, 1'b1);
        clear_errors("clr2");

        @(negedge clk) stray_ack = 1'b1;
        @(negedge clk) stray_ack = 1'b0;
        run_sweep("noen", 3'b000, 0, 0, 0, 16'hDEAD, 16'hDEAD, 16'hDEAD, 1'b0);

        // reset while converting Y, with ISSIHI held high through release
        rsp_delay[0] = 0; rsp_delay[1] = -1; rsp_delay[2] = 0;
        rsp_data[0] = 16'h4242;
        i_chan_en = 3'b111;
        pulse_issihi();
        cnt = 0;
        while (!(o_conv_req && o_conv_sel == 2'd1) && cnt < 300) begin @(negedge clk); cnt++; end
        check("rmid_reach", 32'(o_conv_req && o_conv_sel == 2'd1), 32'd1);
        check("rmid_x_pre", 32'(o_angle_x), 32'h4242);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rmid_req", 32'(o_conv_req), 32'd0);
        check("rmid_busy", 32'(o_busy), 32'd0);
        check("rmid_angles", {o_angle_x, o_angle_y | o_angle_z}, 32'd0);
        i_issihi = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) m_angle[c] = 16'h0000;
        m_tmo = 3'b000; m_ovr = 1'b0;
        b_busy = n_busy;
        repeat (20) @(negedge clk);
        check("rmid_held_high", 32'(n_busy - b_busy), 32'd0);
        $display("reset mid-sweep busy=%b req=%b angle_x=%h", o_busy, o_conv_req, o_angle_x);
        i_issihi = 1'b0;
        repeat (5) @(negedge clk);
        run_sweep("after_rst", 3'b011, 0, 4, 0, 16'hC001, 16'hC002, 16'hC003, 1'b0);

        for (int it = 0; it < 6; it++) begin
            for (int c = 0; c < 3; c++) begin
                int r;
                r = int'($urandom_range(0, 9));
                dsel[c] = (r < 7) ? int'($urandom_range(0, 5)) : (r == 7) ? 63 : (r == 8) ? 64 : -1;
            end
            run_sweep($sformatf("rand%0d", it), 3'($urandom_range(1, 7)), dsel[0], dsel[1], dsel[2],
                      16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
